// File: rtl/miner_pkg.sv
// Shared types and helpers for the SHA-256d miner datapath: FSM states,
// compact-target expansion and the digest byte swap used by every compare.
package miner_pkg;

  localparam int HASH_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN
  } state_e;

  // Compact {mantissa[23:0], exponent[7:0]} to a full 256-bit target.
  function automatic logic [HASH_W-1:0] compact_to_target(input logic [31:0] compact);
    logic [HASH_W-1:0] t;
    logic [7:0]        e;
    e = compact[7:0];
    if (e < 8'd3)
      t = '0;
    else if (e > 8'd32)
      t = '1;
    else
      t = {{(HASH_W-24){1'b0}}, compact[31:8]} << (8 * (int'(e) - 3));
    return t;
  endfunction

  // Hasher emits the digest little-endian; byte 0 becomes the numeric MSB.
  function automatic logic [HASH_W-1:0] byte_swap256(input logic [HASH_W-1:0] d);
    logic [HASH_W-1:0] r;
    for (int i = 0; i < HASH_W / 8; i++)
      r[HASH_W-8-8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/share_fifo.sv
// Synchronous FIFO with show-ahead head, synchronous flush, and a push that is
// accepted while full when a pop happens on the same edge.
module share_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers/count define validity,
  // and a reset on the array would cost a mux per bit for no behavioural gain.
  always_ff @(posedge CLK) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/share_capture.sv
// Compares final SHA-256d digests against the job target, recovers the
// {time, nonce} of each hit by counting results, and queues shares for the host.
module share_capture
  import miner_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       time_in,
  input  logic [31:0]       nonce_in,
  input  logic [31:0]       target_in,
  input  logic              hash_valid,
  input  logic [HASH_W-1:0] hash_in,
  output logic              share_valid,
  input  logic              share_ready,
  output logic [31:0]       share_time,
  output logic [31:0]       share_nonce,
  output logic [HASH_W-1:0] share_hash,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              busy
);

  localparam int ENTRY_W = 64 + HASH_W;

  state_e             state;
  logic [63:0]        counter;
  logic [HASH_W-1:0]  target;
  logic               hit_q;
  logic [ENTRY_W-1:0] hit_entry;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] hold;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               drop;

  // A hit still in the compare register is discarded by start or stop.
  assign push = hit_q && !start && !stop;
  assign pop  = share_ready && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  share_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (start),
    .push      (push),
    .push_data (hit_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: every register here uses non-blocking assignment so each one sees
  // the pre-edge value of the others regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      counter    <= '0;
      target     <= '0;
      hit_q      <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      hit_q <= 1'b0;
      if (start) begin
        state      <= ST_ARM;
        counter    <= {time_in, nonce_in};
        target     <= compact_to_target(target_in);
        overflow   <= 1'b0;
        drop_count <= '0;
      end else if (stop) begin
        state <= ST_IDLE;
      end else begin
        if (drop) begin
          overflow <= 1'b1;
          if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
        unique case (state)
          ST_ARM: state <= ST_RUN;
          ST_RUN: begin
            if (hash_valid) begin
              hit_q   <= (byte_swap256(hash_in) < target);
              counter <= counter + 64'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (hash_valid) hit_entry <= {counter, hash_in};
  end

  // Last head shown is retained so the share outputs hold once the queue drains.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)             hold <= '0;
    else if (!fifo_empty) hold <= head;
  end

  assign share_valid = !fifo_empty;
  assign {share_time, share_nonce, share_hash} = fifo_empty ? hold : head;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_share_capture.sv
// Directed bench for share_capture: table-driven target compares plus
// hand-written sequences for nonce recovery, overflow, abort and reset.
module tb_share_capture;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [31:0]  time_in = '0;
  logic [31:0]  nonce_in = '0;
  logic [31:0]  target_in = '0;
  logic         hash_valid = 1'b0;
  logic [255:0] hash_in = '0;
  logic         share_valid;
  logic         share_ready = 1'b0;
  logic [31:0]  share_time;
  logic [31:0]  share_nonce;
  logic [255:0] share_hash;
  logic         overflow;
  logic [7:0]   drop_count;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  share_capture #(.FIFO_DEPTH(4), .DROP_W(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .stop        (stop),
    .time_in     (time_in),
    .nonce_in    (nonce_in),
    .target_in   (target_in),
    .hash_valid  (hash_valid),
    .hash_in     (hash_in),
    .share_valid (share_valid),
    .share_ready (share_ready),
    .share_time  (share_time),
    .share_nonce (share_nonce),
    .share_hash  (share_hash),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0]  compact;
    logic [255:0] val;      // numeric value the comparator should see
    logic         exp_hit;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] tb_swap(input logic [255:0] v);
    logic [255:0] r;
    for (int b = 0; b < 32; b++) r[255-8*b -: 8] = v[8*b +: 8];
    return r;
  endfunction

  // Returns at the falling edge of the first RUN cycle.
  task automatic job(input logic [31:0] t, input logic [31:0] n, input logic [31:0] c);
    @(negedge CLK);
    start = 1'b1; time_in = t; nonce_in = n; target_in = c;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
  endtask

  task automatic hv(input logic [255:0] h);
    hash_valid = 1'b1; hash_in = h;
    @(negedge CLK);
    hash_valid = 1'b0;
  endtask

  task automatic pop_one();
    share_ready = 1'b1;
    @(negedge CLK);
    share_ready = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [31:0] t, input logic [31:0] n,
                             input logic [255:0] h);
    check({name, " valid"}, share_valid, 1);
    check({name, " time"},  share_time, t);
    check({name, " nonce"}, share_nonce, n);
    check({name, " hash"},  share_hash, h);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h00FFFF1D, (256'hFFFF << 208) - 256'd1, 1'b1};
    vecs[1]  = '{32'h00FFFF1D, 256'hFFFF << 208,            1'b0};
    vecs[2]  = '{32'h00FFFF1D, 256'd0,                      1'b1};
    vecs[3]  = '{32'h12345602, 256'd0,                      1'b0};
    vecs[4]  = '{32'h00000121, ~256'd1,                     1'b1};
    vecs[5]  = '{32'h00000121, ~256'd0,                     1'b0};
    vecs[6]  = '{32'h00000103, 256'd0,                      1'b1};
    vecs[7]  = '{32'h00000103, 256'd1,                      1'b0};
    vecs[8]  = '{32'h80000020, (256'd1 << 255) - 256'd1,    1'b1};
    vecs[9]  = '{32'h80000020, 256'd1 << 255,               1'b0};
    vecs[10] = '{32'h0000FF22, 256'h1234,                   1'b1};

    // Power-on reset
    #2 RST = 1'b0;
    #10;
    check("rst share_valid", share_valid, 0);
    check("rst share_time",  share_time, 0);
    check("rst share_nonce", share_nonce, 0);
    check("rst share_hash",  share_hash, 0);
    check("rst overflow",    overflow, 0);
    check("rst drop_count",  drop_count, 0);
    check("rst busy",        busy, 0);
    @(negedge CLK);
    RST = 1'b1;

    // IDLE ignores hash_valid
    hv(256'd0);
    @(negedge CLK);
    check("idle no share", share_valid, 0);

    // Target expansion and compare boundaries
    for (int i = 0; i < 11; i++) begin
      job(32'(i), 32'h100 + 32'(i), vecs[i].compact);
      check($sformatf("vec%0d busy", i), busy, 1);
      hv(tb_swap(vecs[i].val));
      @(negedge CLK);
      check($sformatf("vec%0d hit", i), share_valid, vecs[i].exp_hit);
      if (vecs[i].exp_hit) begin
        check($sformatf("vec%0d time", i), share_time, 32'(i));
        check($sformatf("vec%0d nonce", i), share_nonce, 32'h100 + 32'(i));
        check($sformatf("vec%0d hash", i), share_hash, tb_swap(vecs[i].val));
        pop_one();
      end
    end

    // Nonce recovery across the nonce->time carry
    job(32'h5, 32'hFFFF_FFFE, 32'h00000121);
    hv(~256'd0);
    hv(~256'd0);
    hv(256'hAA);
    @(negedge CLK);
    hv(256'hBB);
    @(negedge CLK);
    expect_head("rec A", 32'h6, 32'h0, 256'hAA);
    pop_one();
    expect_head("rec B", 32'h6, 32'h1, 256'hBB);
    pop_one();
    check("rec empty", share_valid, 0);
    check("rec hold nonce", share_nonce, 32'h1);
    check("rec hold hash", share_hash, 256'hBB);

    // Overflow: 6 back-to-back hits into a 4-deep queue
    job(32'h77, 32'h1000, 32'h00000121);
    for (int k = 1; k <= 6; k++) hv(256'(k));
    @(negedge CLK);
    check("ovf flag", overflow, 1);
    check("ovf drop_count", drop_count, 2);
    check("ovf head stable", share_hash, 256'd1);
    @(negedge CLK);
    check("ovf head held", share_hash, 256'd1);

    // Full queue: hit lands on the same edge as a pop, no drop
    hash_valid = 1'b1; hash_in = 256'd7;
    @(negedge CLK);
    hash_valid = 1'b0; share_ready = 1'b1;
    @(negedge CLK);
    share_ready = 1'b0;
    check("fullpop drop_count", drop_count, 2);
    expect_head("drain 0", 32'h77, 32'h1001, 256'd2);
    pop_one();
    expect_head("drain 1", 32'h77, 32'h1002, 256'd3);
    pop_one();
    expect_head("drain 2", 32'h77, 32'h1003, 256'd4);
    pop_one();
    expect_head("drain 3", 32'h77, 32'h1006, 256'd7);
    pop_one();
    check("drain empty", share_valid, 0);
    check("ovf sticky", overflow, 1);

    // Abort: 2 queued plus one in the compare register when start arrives
    hv(256'd8);
    hv(256'd9);
    hash_valid = 1'b1; hash_in = 256'd10;
    @(negedge CLK);
    hash_valid = 1'b0;
    start = 1'b1; time_in = 32'hCAFE; nonce_in = 32'h00BE_EF00; target_in = 32'h00000121;
    @(negedge CLK);
    start = 1'b0;
    check("abort empty", share_valid, 0);
    check("abort overflow", overflow, 0);
    check("abort drop_count", drop_count, 0);
    @(negedge CLK);
    check("abort in-flight gone", share_valid, 0);
    hv(256'd11);
    @(negedge CLK);
    expect_head("abort new base", 32'hCAFE, 32'h00BE_EF00, 256'd11);
    pop_one();

    // stop returns to IDLE and results are then ignored
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    check("stop busy", busy, 0);
    hv(256'd12);
    @(negedge CLK);
    check("stop ignores", share_valid, 0);

    // Async reset between edges mid-RUN
    job(32'h9, 32'h9, 32'h00000121);
    hv(256'd13);
    @(negedge CLK);
    check("pre-rst valid", share_valid, 1);
    #2 RST = 1'b0;
    #1;
    check("arst share_valid", share_valid, 0);
    check("arst share_hash",  share_hash, 0);
    check("arst share_nonce", share_nonce, 0);
    check("arst busy",        busy, 0);
    @(negedge CLK);
    RST = 1'b1;
    hv(256'd14);
    @(negedge CLK);
    @(negedge CLK);
    check("post-rst ignores", share_valid, 0);
    check("post-rst busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/share_capture.md
# share_capture

Downstream stage of the SHA-256d hasher: consumes the stream of final hashes, compares each against the job target, and recovers the time/nonce word for every hit. Hits (shares) are queued in a small FIFO and presented to the host interface over a valid/ready handshake. Hash pipeline latency is irrelevant: nonces are recovered by counting accepted results from the job base.

## Interface
Parameters
- FIFO_DEPTH, 4, share queue entries (power of two, ≥2)
- DROP_W, 8, width of the saturating dropped-share counter

Ports
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- start  in  1  load new job; abort current job
- stop  in  1  return to IDLE; queue retained
- time_in  in  32  job base time word, sampled on start
- nonce_in  in  32  job base nonce, sampled on start
- target_in  in  32  compact target {mantissa[23:0], exponent[7:0]}, sampled on start
- hash_valid  in  1  hash_in carries a real result this cycle
- hash_in  in  256  final SHA-256d digest, hasher byte order
- share_valid  out  1  queue head valid
- share_ready  in  1  host accepts head
- share_time  out  32  time word of head share
- share_nonce  out  32  nonce of head share
- share_hash  out  256  digest of head share, unswapped
- overflow  out  1  sticky: a hit was dropped since last start
- drop_count  out  DROP_W  saturating count of dropped hits
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ARM, RUN.
- IDLE: hash_valid ignored. start → ARM.
- ARM (exactly one cycle): latch base {time_in, nonce_in} into 64-bit counter; expand target into 256-bit register; flush queue; clear overflow, drop_count. → RUN.
- RUN: each hash_valid compares byte-reversed hash_in (byte 0 becomes MSB) against target; hit when strictly less. Hit entry = {counter time, counter nonce, hash_in}. Counter increments by 1 on every hash_valid, hit or not. stop → IDLE. start → ARM.
- start has priority over stop; both honoured in any state.
- Target expansion: m = target_in[31:8], e = target_in[7:0]. e < 3 → target = 0 (no hits). 3 ≤ e ≤ 32 → target = m << 8·(e−3). e > 32 → target = all ones.
- Counter is a 64-bit {time, nonce}; nonce carries into time; all-ones wraps to 0 silently.
- Queue full at hit time: hit dropped, overflow set, drop_count += 1 saturating at all ones. Pop in same cycle as full-push frees a slot: push accepted, no drop.
- Hits already in the compare register when start/stop arrives are discarded.
- Outputs share_time/nonce/hash hold head entry; stable while share_valid && !share_ready. Empty queue: outputs hold last value, share_valid = 0.

## Timing
- Reset values: share_valid 0, share_time/nonce/hash 0, overflow 0, drop_count 0, busy 0, state IDLE, counter 0, target 0, queue empty.
- start at edge t → ARM during cycle t+1 → RUN from edge t+2. busy rises after edge t.
- hash_valid sampled at edge t: compare registered at t; queue written at edge t+1; share_valid high after t+1 (latency 2 edges). hash_valid during ARM ignored.
- Pop: share_valid && share_ready at an edge removes head; next entry visible after same edge.
- Back-to-back hits every cycle sustained until queue full.
- Reset mid-operation: all state to reset values immediately, queue emptied.

## Structure
- Package miner_pkg: state enum, HASH_W = 256, compact-to-target function, 256-bit byte-swap function (shared with hasher compare).
- Sub-module share_fifo: synchronous FIFO, parameterised width/depth, push/pop/full/empty, simultaneous push+pop when full allowed.
- Top contains FSM, counter, target register, compare register.

## Test plan
- Expansion: target_in 0x00FFFF1D → target 0xFFFF << 208; e=0x02 → 0; e=0x21 → all ones; hash with swapped value = target−1 hits, = target misses.
- Recovery: base time 0x5, nonce 0xFFFFFFFE, hits on 3rd and 4th hash_valid → shares {0x6, 0x0} and {0x6, 0x1}; non-hit results between them still advance counter.
- Overflow: FIFO_DEPTH 4, share_ready 0, 6 consecutive hits → 4 queued, overflow 1, drop_count 2; then drain 4 in order with share_ready 1.
- Full with simultaneous pop: queue full, share_ready 1 and hit same cycle → no drop, count stays 4.
- Abort: start during RUN with 2 queued and a hit in flight → queue empty, overflow 0, counter = new base, in-flight hit not queued.
- Async reset asserted mid-RUN between edges → all outputs reset values before next edge; hash_valid ignored until new start.
